alsu_rr_scheduler: RTL and testbench

- Shares one ALSU instance between NUM_REQ requesters.
- Arbitrates requests round-robin and drives the ALSU command inputs from registers.
- Tracks the ALSU's fixed pipeline latency with a tag shift register and returns each result, tagged with the requester id, through a credit-limited response FIFO with valid/ready.
- Sits between the requester agents and the ALSU top; the ALSU itself is unchanged.

---
 rtl/alsu_rr_scheduler_if.sv | 52 +++++
 rtl/alsu_rr_scheduler.sv | 155 +++++++++++++++
 tb/tb_alsu_rr_scheduler.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alsu_rr_scheduler_if.sv
// rtl/alsu_rr_scheduler_if.sv - requester, ALSU command and response bundle for alsu_rr_scheduler
interface alsu_rr_scheduler_if #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH_IN  = 3,
  parameter int WIDTH_OUT = 6
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*3-1:0]        req_opcode;
  logic [NUM_REQ*WIDTH_IN-1:0] req_a;
  logic [NUM_REQ*WIDTH_IN-1:0] req_b;
  logic [NUM_REQ-1:0]          req_cin;
  logic [NUM_REQ*4-1:0]        req_flags;

  logic [WIDTH_IN-1:0]  alsu_A;
  logic [WIDTH_IN-1:0]  alsu_B;
  logic [2:0]           alsu_opcode;
  logic                 alsu_cin;
  logic                 alsu_red_op_A;
  logic                 alsu_red_op_B;
  logic                 alsu_bypass_A;
  logic                 alsu_bypass_B;
  logic [WIDTH_OUT-1:0] alsu_out;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [WIDTH_OUT-1:0] rsp_data;
  logic                 rsp_invalid;

  modport master (
    output req_valid, req_opcode, req_a, req_b, req_cin, req_flags,
    input  req_ready,
    input  alsu_A, alsu_B, alsu_opcode, alsu_cin,
    input  alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B,
    output alsu_out,
    input  rsp_valid, rsp_id, rsp_data, rsp_invalid,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, req_cin, req_flags,
    output req_ready,
    output alsu_A, alsu_B, alsu_opcode, alsu_cin,
    output alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B,
    input  alsu_out,
    output rsp_valid, rsp_id, rsp_data, rsp_invalid,
    input  rsp_ready
  );
endinterface

// File: rtl/alsu_rr_scheduler.sv
// rtl/alsu_rr_scheduler.sv - round-robin sharing of one ALSU with tagged, credit-limited responses
// Optional: INVALID_FILTER_EN replaces invalid requests with a NOP towards the ALSU.
module alsu_rr_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH_IN  = 3,
  parameter int WIDTH_OUT = 6,
  parameter int LATENCY   = 2,
  parameter int RSP_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  alsu_rr_scheduler_if.slave bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int NS  = LATENCY + 1;
  localparam int PW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW  = $clog2(RSP_DEPTH + 1);
  localparam int OW  = $clog2(NS + RSP_DEPTH + 1);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
    logic           inv;
  } tag_t;

  logic [IDW-1:0] ptr_q;
  tag_t           tag_q [NS];
  logic [PW-1:0]  wr_q, rd_q;
  logic [CW-1:0]  cnt_q;

  logic [IDW-1:0]       id_mem   [RSP_DEPTH];
  logic [WIDTH_OUT-1:0] data_mem [RSP_DEPTH];
  logic                 inv_mem  [RSP_DEPTH];

  logic           found;
  logic [IDW-1:0] gnt_idx, cand;
  logic [OW-1:0]  outstanding;
  logic           credit_ok, grant, issue;
  logic [2:0]          g_op;
  logic [WIDTH_IN-1:0] g_a, g_b;
  logic                g_cin, g_inv;
  logic [3:0]          g_flags;
  logic                push, pop;
  logic [WIDTH_OUT-1:0] push_data;

  // First valid requester at or after the pointer, wrapping naturally in IDW bits.
  always_comb begin
    found   = 1'b0;
    gnt_idx = ptr_q;
    cand    = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ptr_q + IDW'(k);
      if (!found && bus.req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    outstanding = OW'(cnt_q);
    for (int s = 0; s < NS; s++) begin
      outstanding = outstanding + OW'(tag_q[s].vld);
    end
  end

  assign credit_ok     = outstanding < OW'(RSP_DEPTH);
  assign grant         = found & credit_ok & ~rst;
  assign bus.req_ready = grant ? (NUM_REQ'(1) << gnt_idx) : '0;

  always_comb begin
    g_op    = bus.req_opcode[3*int'(gnt_idx) +: 3];
    g_a     = bus.req_a[WIDTH_IN*int'(gnt_idx) +: WIDTH_IN];
    g_b     = bus.req_b[WIDTH_IN*int'(gnt_idx) +: WIDTH_IN];
    g_cin   = bus.req_cin[gnt_idx];
    g_flags = bus.req_flags[4*int'(gnt_idx) +: 4];
    g_inv   = ((g_flags[0] | g_flags[1]) & (g_op[1] | g_op[2])) | (g_op[1] & g_op[2]);
  end

`ifdef INVALID_FILTER_EN
  assign issue = grant & ~g_inv;
`else
  assign issue = grant;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.alsu_A        <= '0;
      bus.alsu_B        <= '0;
      bus.alsu_opcode   <= '0;
      bus.alsu_cin      <= 1'b0;
      bus.alsu_red_op_A <= 1'b0;
      bus.alsu_red_op_B <= 1'b0;
      bus.alsu_bypass_A <= 1'b0;
      bus.alsu_bypass_B <= 1'b0;
      ptr_q             <= '0;
      for (int s = 0; s < NS; s++) tag_q[s] <= '0;
    end else begin
      bus.alsu_A        <= issue ? g_a : '0;
      bus.alsu_B        <= issue ? g_b : '0;
      bus.alsu_opcode   <= issue ? g_op : 3'd0;
      bus.alsu_cin      <= issue & g_cin;
      bus.alsu_red_op_A <= issue & g_flags[0];
      bus.alsu_red_op_B <= issue & g_flags[1];
      bus.alsu_bypass_A <= issue & g_flags[2];
      bus.alsu_bypass_B <= issue & g_flags[3];
      if (grant) ptr_q <= gnt_idx + IDW'(1);
      tag_q[0] <= grant ? tag_t'({1'b1, gnt_idx, g_inv}) : '0;
      for (int s = 1; s < NS; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  // The last tag stage lines up with the cycle alsu_out carries that operation's result.
  assign push = tag_q[NS-1].vld;
  assign pop  = (cnt_q != '0) & bus.rsp_ready;

`ifdef INVALID_FILTER_EN
  assign push_data = tag_q[NS-1].inv ? '0 : bus.alsu_out;
`else
  assign push_data = bus.alsu_out;
`endif

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= nxt(wr_q);
      if (pop)  rd_q <= nxt(rd_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[wr_q]   <= tag_q[NS-1].id;
      data_mem[wr_q] <= push_data;
      inv_mem[wr_q]  <= tag_q[NS-1].inv;
    end
  end

  assign bus.rsp_valid   = (cnt_q != '0);
  assign bus.rsp_id      = bus.rsp_valid ? id_mem[rd_q] : '0;
  assign bus.rsp_data    = bus.rsp_valid ? data_mem[rd_q] : '0;
  assign bus.rsp_invalid = bus.rsp_valid & inv_mem[rd_q];
endmodule

// File: tb/tb_alsu_rr_scheduler.sv
// tb/tb_alsu_rr_scheduler.sv - scoreboard bench for alsu_rr_scheduler with a two-stage ALSU stand-in
module tb_alsu_rr_scheduler;
  localparam int NR = 4;
  localparam int WI = 3;
  localparam int WO = 6;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alsu_rr_scheduler_if #(.NUM_REQ(NR), .WIDTH_IN(WI), .WIDTH_OUT(WO)) bus ();

  alsu_rr_scheduler #(.NUM_REQ(NR), .WIDTH_IN(WI), .WIDTH_OUT(WO), .LATENCY(2), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [2:0]    op   [NR];
  logic [WI-1:0] a    [NR];
  logic [WI-1:0] b    [NR];
  logic          cin  [NR];
  logic [3:0]    flg  [NR];

  always_comb begin
    bus.req_opcode = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_cin    = '0;
    bus.req_flags  = '0;
    for (int i = 0; i < NR; i++) begin
      bus.req_opcode[3*i +: 3] = op[i];
      bus.req_a[WI*i +: WI]    = a[i];
      bus.req_b[WI*i +: WI]    = b[i];
      bus.req_cin[i]           = cin[i];
      bus.req_flags[4*i +: 4]  = flg[i];
    end
  end

  // ALSU stand-in: inputs captured one edge after issue, result registered one edge later
  logic [2:0]    s_op;
  logic [WI-1:0] s_a, s_b;
  logic          s_cin;
  function automatic logic [WO-1:0] alsu_f(input logic [2:0] o, input logic [WI-1:0] x, input logic [WI-1:0] y, input logic c);
    case (o)
      3'd0:    return WO'(x & y);
      3'd1:    return WO'(x ^ y);
      3'd2:    return WO'(x) + WO'(y) + WO'(c);
      3'd3:    return WO'(x) * WO'(y);
      default: return '0;
    endcase
  endfunction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_op <= '0; s_a <= '0; s_b <= '0; s_cin <= 1'b0; bus.alsu_out <= '0;
    end else begin
      s_op <= bus.alsu_opcode; s_a <= bus.alsu_A; s_b <= bus.alsu_B; s_cin <= bus.alsu_cin;
      bus.alsu_out <= alsu_f(s_op, s_a, s_b, s_cin);
    end
  end

  typedef struct { int id; int data; int inv; } exp_t;
  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int outst = 0;
  int ed[NR] = '{6, 4, 6, 21};

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void push_exp(input int id, input int data, input int inv);
    exp_t e;
    e.id = id; e.data = data; e.inv = inv;
    q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (|bus.req_ready) begin
        chk("grant_onehot", int'($onehot(bus.req_ready)), 1);
        chk("grant_credit", int'(outst < DEPTH), 1);
        outst++;
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_rsp: got id %0d data %0d, expected no response", bus.rsp_id, bus.rsp_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_id", int'(bus.rsp_id), e.id);
          chk("rsp_data", int'(bus.rsp_data), e.data);
          chk("rsp_invalid", int'(bus.rsp_invalid), e.inv);
        end
        outst--;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int c = 0; c < 40; c++) begin
      if (q.size() == 0 && outst == 0) break;
      step();
    end
    chk("drain_pending", q.size(), 0);
    chk("drain_outstanding", outst, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ng;
    int exp_rr[5]  = '{1, 2, 4, 8, 1};
    int ids_rr[5]  = '{0, 1, 2, 3, 0};
    int exp_fl[4]  = '{2, 4, 8, 1};
    int ids_fl[4]  = '{1, 2, 3, 0};

    op[0] = 3'd2; a[0] = 3'd3; b[0] = 3'd2; cin[0] = 1'b1; flg[0] = 4'd0;
    op[1] = 3'd0; a[1] = 3'd5; b[1] = 3'd6; cin[1] = 1'b0; flg[1] = 4'd0;
    op[2] = 3'd1; a[2] = 3'd5; b[2] = 3'd3; cin[2] = 1'b0; flg[2] = 4'd0;
    op[3] = 3'd3; a[3] = 3'd3; b[3] = 3'd7; cin[3] = 1'b0; flg[3] = 4'd0;
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;

    // reset state, with requests pending
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", int'(bus.req_ready), 0);
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_rsp_id", int'(bus.rsp_id), 0);
    chk("rst_rsp_data", int'(bus.rsp_data), 0);
    chk("rst_rsp_invalid", int'(bus.rsp_invalid), 0);
    chk("rst_alsu_opcode", int'(bus.alsu_opcode), 0);
    chk("rst_alsu_A", int'(bus.alsu_A), 0);
    bus.req_valid = '0;
    rst = 1'b0;

    // all four requesting, consumer always ready
    step();
    bus.req_valid = 4'b1111;
    ng = 0;
    for (int c = 0; c < 15 && ng < 5; c++) begin
      @(negedge clk);
      if (|bus.req_ready) begin
        chk("rr_seq", int'(bus.req_ready), exp_rr[ng]);
        push_exp(ids_rr[ng], ed[ids_rr[ng]], 0);
        ng++;
      end
      step();
    end
    bus.req_valid = '0;
    chk("rr_grant_count", ng, 5);
    drain();

    // consumer stalled: credits run out after four grants
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1111;
    ng = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (|bus.req_ready) begin
        if (ng < 4) begin
          chk("fill_seq", int'(bus.req_ready), exp_fl[ng]);
          push_exp(ids_fl[ng], ed[ids_fl[ng]], 0);
        end else begin
          chk("fill_extra_grant", int'(bus.req_ready), 0);
        end
        ng++;
      end
      step();
    end
    chk("fill_grant_count", ng, 4);
    chk("fill_rsp_valid", int'(bus.rsp_valid), 1);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("pop_cycle_no_grant", int'(bus.req_ready), 0);
    step();
    @(negedge clk);
    chk("resume_grant", int'(bus.req_ready), 2);
    push_exp(1, ed[1], 0);
    step();
    bus.req_valid = '0;
    drain();

    // pointer at 2, requesters 1 and 3
    bus.req_valid = 4'b1010;
    @(negedge clk);
    chk("rr_wrap_first", int'(bus.req_ready), 8);
    push_exp(3, ed[3], 0);
    step();
    @(negedge clk);
    chk("rr_wrap_second", int'(bus.req_ready), 2);
    push_exp(1, ed[1], 0);
    step();
    bus.req_valid = '0;
    drain();

    // invalid opcode from requester 2; pointer should still be 2
    op[2] = 3'd6;
    bus.req_valid = 4'b0111;
    @(negedge clk);
    chk("inv_grant", int'(bus.req_ready), 4);
    push_exp(2, 0, 1);
    step();
    bus.req_valid = '0;
    @(negedge clk);
`ifdef INVALID_FILTER_EN
    chk("inv_alsu_opcode", int'(bus.alsu_opcode), 0);
`else
    chk("inv_alsu_opcode", int'(bus.alsu_opcode), 6);
`endif
    step();
    @(negedge clk);
    chk("inv_alsu_opcode_next", int'(bus.alsu_opcode), 0);
    drain();
    op[2] = 3'd1;

    // single ADD from requester 0: latency check
    bus.req_valid = 4'b0001;
    @(negedge clk);
    chk("add_grant", int'(bus.req_ready), 1);
    push_exp(0, 6, 0);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("add_alsu_opcode", int'(bus.alsu_opcode), 2);
    chk("add_alsu_A", int'(bus.alsu_A), 3);
    chk("add_alsu_cin", int'(bus.alsu_cin), 1);
    chk("add_rsp_valid_e0", int'(bus.rsp_valid), 0);
    for (int k = 1; k <= 3; k++) begin
      step();
      @(negedge clk);
      chk("add_rsp_valid_timing", int'(bus.rsp_valid), (k == 3) ? 1 : 0);
    end
    drain();

    // reset with two results in flight and two queued
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1111;
    ng = 0;
    for (int c = 0; c < 10 && ng < 4; c++) begin
      @(negedge clk);
      if (|bus.req_ready) ng++;
      step();
    end
    chk("prereset_grants", ng, 4);
    bus.req_valid = '0;
    step();
    chk("prereset_rsp_valid", int'(bus.rsp_valid), 1);
    bus.req_valid = 4'b1100;
    rst = 1'b1;
    #1;
    q.delete();
    outst = 0;
    chk("midrst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("midrst_req_ready", int'(bus.req_ready), 0);
    chk("midrst_alsu_opcode", int'(bus.alsu_opcode), 0);
    chk("midrst_alsu_B", int'(bus.alsu_B), 0);
    chk("midrst_alsu_cin", int'(bus.alsu_cin), 0);
    bus.req_valid = '0;
    repeat (2) step();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("postrst_no_rsp", int'(bus.rsp_valid), 0);
      step();
    end
    bus.req_valid = 4'b1100;
    @(negedge clk);
    chk("postrst_first_grant", int'(bus.req_ready), 4);
    push_exp(2, ed[2], 0);
    step();
    bus.req_valid = '0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
